// File: rtl/aud_adc_capture.sv
//------------------------------------------------------------------------------
// Module   : aud_adc_capture
// Function : WM8731 I2S ADC receiver. Deserialises ADCDAT into signed PCM
//            words and queues them in a show-ahead FIFO. Optional mono
//            downmix of each L/R pair is enabled by AUD_CAP_MONO_MIX_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aud_adc_capture #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_lrc,
    input  logic                          i_adcdat,
    input  logic                          i_en,
    input  logic                          i_clr_flags,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_chan,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_frame_err
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_CNT_W = $clog2(DATA_W);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

    // The LRC edge cycle itself is the I2S delay bit, so SYNC/HOLD go
    // straight to SHIFT and no separate skip state is needed.
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SYNC  = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd3;
    localparam logic [2:0] c_HOLD  = 3'd4;

    logic [2:0]          r_state;
    logic                r_lrc_d;
    logic                r_chan;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-2:0]   r_shreg;

    logic                w_edge;
    logic                w_in_shift;
    logic                w_word_done;
    logic                w_frame_evt;
    logic [DATA_W-1:0]   w_word;

    logic                w_push_req;
    logic [DATA_W-1:0]   w_push_data;
    logic                w_push_chan;

    assign w_edge      = i_lrc ^ r_lrc_d;
    assign w_in_shift  = (r_state == c_SHIFT);
    assign w_word      = {r_shreg, i_adcdat};
    assign w_word_done = i_en & w_in_shift & ~w_edge & (r_cnt == c_LAST);
    assign w_frame_evt = i_en & w_in_shift & w_edge;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_lrc_d <= 1'b0;
            r_chan  <= 1'b0;
            r_cnt   <= '0;
            r_shreg <= '0;
        end else begin
            r_lrc_d <= i_lrc;
            if (!i_en) begin
                r_state <= c_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    c_IDLE: r_state <= c_SYNC;
                    c_SYNC, c_HOLD: begin
                        if (w_edge) begin
                            r_state <= c_SHIFT;
                            r_chan  <= i_lrc;
                            r_cnt   <= '0;
                        end
                    end
                    c_SHIFT: begin
                        if (w_edge) begin
                            // truncated slot: drop partial word, restart on new channel
                            r_chan <= i_lrc;
                            r_cnt  <= '0;
                        end else begin
                            r_shreg <= w_word[DATA_W-2:0];
                            if (r_cnt == c_LAST) begin
                                r_state <= c_HOLD;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

`ifdef AUD_CAP_MONO_MIX_EN
    logic [DATA_W-1:0] r_left;
    logic              r_left_vld;
    logic [DATA_W:0]   w_sum;

    // Sign-extended sum; bits [DATA_W:1] give the arithmetic shift right by one.
    assign w_sum       = {r_left[DATA_W-1], r_left} + {w_word[DATA_W-1], w_word};
    assign w_push_req  = w_word_done & r_chan & r_left_vld;
    assign w_push_data = w_sum[DATA_W:1];
    assign w_push_chan = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_left     <= '0;
            r_left_vld <= 1'b0;
        end else if (!i_en || w_frame_evt) begin
            r_left_vld <= 1'b0;
        end else if (w_word_done) begin
            if (!r_chan) begin
                r_left     <= w_word;
                r_left_vld <= 1'b1;
            end else begin
                r_left_vld <= 1'b0;
            end
        end
    end
`else
    assign w_push_req  = w_word_done;
    assign w_push_data = w_word;
    assign w_push_chan = r_chan;
`endif

    logic [DATA_W:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                r_overflow;
    logic                r_frame_err;

    logic                w_full;
    logic                w_pop;
    logic                w_push;

    assign o_valid = (r_level != '0);
    assign w_full  = (r_level == c_FULL);
    assign w_pop   = o_valid & i_ready;
    assign w_push  = w_push_req & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_push_chan, w_push_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= (w_push_req & w_full & ~w_pop) | (r_overflow & ~i_clr_flags);
            r_frame_err <= w_frame_evt | (r_frame_err & ~i_clr_flags);
        end
    end

    assign o_data      = r_mem[r_rd_ptr][DATA_W-1:0];
    assign o_chan      = r_mem[r_rd_ptr][DATA_W];
    assign o_level     = r_level;
    assign o_overflow  = r_overflow;
    assign o_frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_aud_adc_capture.sv
//------------------------------------------------------------------------------
// Module   : tb_aud_adc_capture
// Function : Directed self-checking bench for aud_adc_capture; the mono-mix
//            checks run when AUD_CAP_MONO_MIX_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aud_adc_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        lrc;
    logic        adcdat;
    logic        en;
    logic        clr_flags;
    logic [15:0] data;
    logic        chan;
    logic        valid;
    logic        ready;
    logic [3:0]  level;
    logic        overflow;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    logic g_clr_first = 1'b0;
    logic g_ready_last = 1'b0;

    always #5 clk = ~clk;

    aud_adc_capture #(.DATA_W(16), .FIFO_DEPTH(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_lrc       (lrc),
        .i_adcdat    (adcdat),
        .i_en        (en),
        .i_clr_flags (clr_flags),
        .o_data      (data),
        .o_chan      (chan),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_level     (level),
        .o_overflow  (overflow),
        .o_frame_err (frame_err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One slot: delay cycle on the LRC edge, nbits data bits MSB first, extra idle bits.
    task automatic send_slot(input logic ch, input logic [15:0] w, input int nbits, input int extra);
        lrc       = ch;
        adcdat    = 1'b1;
        clr_flags = g_clr_first;
        step;
        clr_flags = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            adcdat = w[15-i];
            if (g_ready_last && i == nbits - 1) ready = 1'b1;
            step;
        end
        if (g_ready_last) ready = 1'b0;
        for (int i = 0; i < extra; i++) begin
            adcdat = ~adcdat;
            step;
        end
    endtask

    task automatic pop_one;
        ready = 1'b1;
        step;
        ready = 1'b0;
    endtask

    initial begin
        logic [15:0] tw;
        rst = 1'b1; en = 1'b0; lrc = 1'b0; adcdat = 1'b0; clr_flags = 1'b0; ready = 1'b0;
        step; step;
        check("rst_data",   32'(data),      32'h0);
        check("rst_chan",   32'(chan),      32'h0);
        check("rst_valid",  32'(valid),     32'h0);
        check("rst_level",  32'(level),     32'h0);
        check("rst_ovf",    32'(overflow),  32'h0);
        check("rst_ferr",   32'(frame_err), 32'h0);
        rst = 1'b0;

        // Enable mid right slot: the partial right word must not be captured.
        en = 1'b1; lrc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adcdat = 1'(i);
            step;
        end
        check("sync_level", 32'(level), 32'h0);

`ifdef AUD_CAP_MONO_MIX_EN
        send_slot(1'b0, 16'h7FFF, 16, 1);
        check("mix_left_held", 32'(level), 32'h0);
        send_slot(1'b1, 16'h0001, 16, 1);
        check("mix1_level", 32'(level), 32'h1);
        check("mix1_data",  32'(data),  32'h4000);
        check("mix1_chan",  32'(chan),  32'h0);
        send_slot(1'b0, 16'h8000, 16, 1);
        send_slot(1'b1, 16'hFFFF, 16, 1);
        check("mix2_level", 32'(level), 32'h2);
        pop_one;
        check("mix2_data",  32'(data),  32'hBFFF);
        check("mix2_chan",  32'(chan),  32'h0);
        check("mix_ovf",    32'(overflow), 32'h0);
`else
        // Basic L/R capture with latency checks.
        ready = 1'b1;
        tw = 16'h1234;
        send_slot(1'b0, tw, 15, 0);
        check("l_valid_early", 32'(valid), 32'h0);
        adcdat = tw[0];
        step;
        check("l_valid", 32'(valid), 32'h1);
        check("l_data",  32'(data),  32'h1234);
        check("l_chan",  32'(chan),  32'h0);
        tw = 16'hFEDC;
        send_slot(1'b1, tw, 15, 0);
        check("r_valid_early", 32'(valid), 32'h0);
        adcdat = tw[0];
        step;
        check("r_valid", 32'(valid), 32'h1);
        check("r_data",  32'(data),  32'hFEDC);
        check("r_chan",  32'(chan),  32'h1);
        step;
        check("lr_drained", 32'(level), 32'h0);
        check("lr_ovf",  32'(overflow),  32'h0);
        check("lr_ferr", 32'(frame_err), 32'h0);

        // Overflow: nine words into eight entries, word 9 dropped.
        ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            send_slot(1'((i - 1) % 2), 16'hA000 + 16'(i), 16, 1);
        end
        check("ovf_level", 32'(level),    32'h8);
        check("ovf_flag",  32'(overflow), 32'h1);
        check("ovf_head",  32'(data),     32'hA001);
        clr_flags = 1'b1;
        step;
        clr_flags = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);
        g_ready_last = 1'b1;
        send_slot(1'b1, 16'hA00A, 16, 1);
        g_ready_last = 1'b0;
        check("full_pushpop_level", 32'(level),    32'h8);
        check("full_pushpop_ovf",   32'(overflow), 32'h0);
        for (int i = 2; i <= 8; i++) begin
            check("drain_data", 32'(data), 32'hA000 + 32'(i));
            check("drain_chan", 32'(chan), 32'((i - 1) % 2));
            pop_one;
        end
        check("drain_last", 32'(data), 32'hA00A);
        pop_one;
        check("drain_empty", 32'(valid), 32'h0);

        // Truncated slot after 10 bits.
        send_slot(1'b0, 16'h5555, 10, 0);
        send_slot(1'b1, 16'h3C3C, 16, 1);
        check("ferr_flag",  32'(frame_err), 32'h1);
        check("ferr_level", 32'(level),     32'h1);
        check("ferr_data",  32'(data),      32'h3C3C);
        check("ferr_chan",  32'(chan),      32'h1);
        pop_one;
        clr_flags = 1'b1;
        step;
        clr_flags = 1'b0;
        check("ferr_clr", 32'(frame_err), 32'h0);
        send_slot(1'b0, 16'h1111, 5, 0);
        g_clr_first = 1'b1;
        send_slot(1'b1, 16'h2222, 16, 1);
        g_clr_first = 1'b0;
        check("ferr_set_wins", 32'(frame_err), 32'h1);
        check("ferr2_data",    32'(data),      32'h2222);
        pop_one;
        clr_flags = 1'b1;
        step;
        clr_flags = 1'b0;
        check("ferr2_clr", 32'(frame_err), 32'h0);

        // Disable mid-word, drain while disabled, then resume.
        send_slot(1'b0, 16'h0F0F, 16, 1);
        tw = 16'hF0F0;
        send_slot(1'b1, tw, 5, 0);
        en = 1'b0;
        for (int i = 5; i < 16; i++) begin
            adcdat = tw[15-i];
            step;
        end
        step; step;
        check("dis_level", 32'(level),     32'h1);
        check("dis_ferr",  32'(frame_err), 32'h0);
        check("dis_data",  32'(data),      32'h0F0F);
        pop_one;
        check("dis_drained", 32'(valid), 32'h0);
        en = 1'b1;
        step; step;
        send_slot(1'b0, 16'h6789, 16, 1);
        check("resume_level", 32'(level), 32'h1);
        check("resume_data",  32'(data),  32'h6789);
        check("resume_chan",  32'(chan),  32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
